// File: rtl/output_byte_drain.sv
// Byte-stream drain buffer: captures fetch-stage bytes into a FWFT FIFO, drains them over
// valid/ready, and issues a single completion pulse once done is seen and the FIFO is empty.
module output_byte_drain #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  input  logic [7:0]    in_data_i,
  input  logic          in_done_i,
  output logic [7:0]    out_data_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [AW:0]   level_o,
  output logic          overflow_o,
  output logic [15:0]   byte_count_o,
  output logic          done_out_o
);

  typedef enum logic [0:0] {StIdle, StPending} state_e;

  localparam logic [AW:0] LevelFull = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   byte_count_q, byte_count_d;
  logic          in_done_q;
  logic          done_q, done_d;
  state_e        state_q, state_d;

  logic push, pop, rise;

  // A full FIFO can still accept a byte when the head leaves in the same cycle.
  assign pop  = out_valid_o & out_ready_i;
  assign push = in_valid_i & ((level_q != LevelFull) | pop);
  assign rise = in_done_i & ~in_done_q;

  assign out_valid_o  = (level_q != '0);
  assign out_data_o   = out_valid_o ? mem_q[rd_ptr_q] : 8'h00;
  assign level_o      = level_q;
  assign overflow_o   = overflow_q;
  assign byte_count_o = byte_count_q;
  assign done_out_o   = done_q;

  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    level_d      = level_q;
    overflow_d   = overflow_q;
    byte_count_d = byte_count_q;
    if (push) begin
      wr_ptr_d     = wr_ptr_q + 1'b1;
      byte_count_d = byte_count_q + 16'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      level_d = level_q + (AW+1)'(1);
    end else if (pop && !push) begin
      level_d = level_q - (AW+1)'(1);
    end
    if (in_valid_i && !push) begin
      overflow_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rise) state_d = StPending;
      end
      StPending: begin
        // Pulse only once every accepted byte has left and nothing new is arriving.
        if ((level_q == '0) && !push) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      byte_count_q <= '0;
      in_done_q    <= 1'b0;
      done_q       <= 1'b0;
      state_q      <= StIdle;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      byte_count_q <= byte_count_d;
      in_done_q    <= in_done_i;
      done_q       <= done_d;
      state_q      <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

endmodule

// File: tb/tb_output_byte_drain.sv
// Directed self-checking bench for output_byte_drain: reset, streaming, back-pressure,
// full-with-pop, and done-pulse ordering.
module tb_output_byte_drain;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic [7:0]  in_data_i = 8'h00;
  logic        in_done_i = 1'b0;
  logic [7:0]  out_data_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [4:0]  level_o;
  logic        overflow_o;
  logic [15:0] byte_count_o;
  logic        done_out_o;

  int checks = 0;
  int failures = 0;

  output_byte_drain #(.DEPTH(16), .AW(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_done_i   (in_done_i),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .level_o     (level_o),
    .overflow_o  (overflow_o),
    .byte_count_o(byte_count_o),
    .done_out_o  (done_out_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    in_valid_i  = 1'b0;
    in_data_i   = 8'h00;
    in_done_i   = 1'b0;
    out_ready_i = 1'b0;
    rst_i       = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    int pulses;
    do_reset();
    checks++;
    if ({out_valid_o, out_data_o, level_o, overflow_o, byte_count_o, done_out_o} !== 32'h0) begin
      failures++;
      $display("FAIL reset_values: got valid=%0b data=%0h level=%0d ovf=%0b cnt=%0d done=%0b required all 0",
               out_valid_o, out_data_o, level_o, overflow_o, byte_count_o, done_out_o);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = 8'h30 + 8'(i);
      tick();
    end
    in_valid_i = 1'b0;
    in_done_i  = 1'b1;
    tick();
    checks++;
    if (level_o !== 5'd5) begin
      failures++;
      $display("FAIL reset_prefill: level got %0d required 5", level_o);
    end
    in_done_i = 1'b0;
    #3;
    rst_i = 1'b1;
    #1;
    checks++;
    if (level_o !== 5'd0 || out_valid_o !== 1'b0 || out_data_o !== 8'h00) begin
      failures++;
      $display("FAIL reset_async: got level=%0d valid=%0b data=%0h required 0 0 00",
               level_o, out_valid_o, out_data_o);
    end
    tick();
    rst_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done_out_o === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL reset_no_done: got %0d pulses required 0", pulses);
    end
  endtask

  task automatic test_stream();
    int bad;
    do_reset();
    out_ready_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = 8'(i + 1);
      tick();
      if (out_valid_o !== 1'b1 || out_data_o !== 8'(i + 1)) begin
        bad++;
        $display("FAIL stream_order: at byte %0d got valid=%0b data=%0h required 1 %0h",
                 i, out_valid_o, out_data_o, i + 1);
      end
    end
    checks++;
    if (bad != 0) failures++;
    in_valid_i = 1'b0;
    tick();
    checks++;
    if (level_o !== 5'd0 || byte_count_o !== 16'd32 || overflow_o !== 1'b0) begin
      failures++;
      $display("FAIL stream_final: got level=%0d cnt=%0d ovf=%0b required 0 32 0",
               level_o, byte_count_o, overflow_o);
    end
  endtask

  task automatic test_full_backpressure();
    int bad;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = 8'hA0 + 8'(i);
      tick();
    end
    in_valid_i = 1'b0;
    checks++;
    if (level_o !== 5'd16 || overflow_o !== 1'b1 || byte_count_o !== 16'd16) begin
      failures++;
      $display("FAIL full_state: got level=%0d ovf=%0b cnt=%0d required 16 1 16",
               level_o, overflow_o, byte_count_o);
    end
    out_ready_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (out_valid_o !== 1'b1 || out_data_o !== 8'hA0 + 8'(i)) begin
        bad++;
        $display("FAIL full_drain: entry %0d got %0h required %0h", i, out_data_o, 8'hA0 + 8'(i));
      end
      tick();
    end
    checks++;
    if (bad != 0) failures++;
    checks++;
    if (level_o !== 5'd0 || out_data_o !== 8'h00 || overflow_o !== 1'b1) begin
      failures++;
      $display("FAIL full_after_drain: got level=%0d data=%0h ovf=%0b required 0 00 1",
               level_o, out_data_o, overflow_o);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_q[$];
    logic [7:0] e;
    int bad;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = 8'h10 + 8'(i);
      exp_q.push_back(in_data_i);
      tick();
    end
    out_ready_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      in_data_i = 8'h50 + 8'(i);
      e = exp_q.pop_front();
      if (out_data_o !== e) begin
        bad++;
        $display("FAIL pushpop_head: got %0h required %0h", out_data_o, e);
      end
      exp_q.push_back(in_data_i);
      tick();
      if (level_o !== 5'd16) begin
        bad++;
        $display("FAIL pushpop_level: got %0d required 16", level_o);
      end
    end
    checks++;
    if (bad != 0) failures++;
    in_valid_i = 1'b0;
    checks++;
    if (overflow_o !== 1'b0 || byte_count_o !== 16'd20) begin
      failures++;
      $display("FAIL pushpop_counts: got ovf=%0b cnt=%0d required 0 20", overflow_o, byte_count_o);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front();
      if (out_valid_o !== 1'b1 || out_data_o !== e) begin
        bad++;
        $display("FAIL pushpop_drain: entry %0d got %0h required %0h", i, out_data_o, e);
      end
      tick();
    end
    checks++;
    if (bad != 0 || level_o !== 5'd0) begin
      failures++;
      $display("FAIL pushpop_drain_total: errors=%0d level=%0d required 0 0", bad, level_o);
    end
  endtask

  task automatic test_done_ordering();
    int pulses;
    int at;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = 8'(i);
      tick();
    end
    in_valid_i = 1'b0;
    in_done_i  = 1'b1;
    pulses = 0;
    at = -1;
    // Pops occur at c=10..25, so the drain condition is seen in c=26 and the pulse follows it.
    for (int c = 0; c < 40; c++) begin
      out_ready_i = (c >= 10);
      tick();
      if (done_out_o === 1'b1) begin
        pulses++;
        at = c;
      end
    end
    in_done_i = 1'b0;
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL done_order_count: got %0d pulses required 1", pulses);
    end
    checks++;
    if (at != 26) begin
      failures++;
      $display("FAIL done_order_timing: pulse at %0d required 26", at);
    end
  endtask

  task automatic test_repeated_done();
    int pulses;
    int first;
    do_reset();
    tick();
    pulses = 0;
    first = -1;
    for (int c = 0; c < 14; c++) begin
      in_done_i = (c < 3) || (c >= 6 && c < 9);
      tick();
      if (done_out_o === 1'b1) begin
        pulses++;
        if (first < 0) first = c;
      end
    end
    checks++;
    if (pulses != 2) begin
      failures++;
      $display("FAIL done_repeat_count: got %0d pulses required 2", pulses);
    end
    checks++;
    if (first != 1) begin
      failures++;
      $display("FAIL done_latency: first pulse at %0d required 1", first);
    end
    in_done_i = 1'b0;
    tick();
    tick();
    pulses = 0;
    in_done_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done_out_o === 1'b1) pulses++;
    end
    in_done_i = 1'b0;
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL done_held: got %0d pulses required 1", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full_backpressure();
    test_full_push_pop();
    test_done_ordering();
    test_repeated_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/output_byte_drain.md
# output_byte_drain

Byte-stream buffer directly downstream of the output fetch stage. It captures each byte the fetch stage presents while its start/valid strobe is high, holds the bytes in a small first-word-fall-through FIFO, and drains them to an external sink over a valid/ready handshake. It also converts the fetch stage's level-style done into a single-cycle completion pulse, issued only after every accepted byte has left the FIFO.

## Interface
- DEPTH, 16: FIFO entries; power of two, ≥2.
- AW, 4: log2(DEPTH).
- clock  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  byte strobe from fetch stage (its StartOut); one byte per cycle while high.
- in_data  input  8  byte from fetch stage (its DataOut).
- in_done  input  1  fetch-stage done; level, may stay high for many cycles.
- out_data  output  8  head-of-FIFO byte; 8'h00 when empty.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  sink accepts out_data this cycle.
- level  output  AW+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; set when an incoming byte is dropped.
- byte_count  output  16  accepted-byte counter, wraps mod 2^16.
- done_out  output  1  one-cycle completion pulse.

## Operation
- Storage: DEPTH×8 array, rd_ptr/wr_ptr AW bits wrapping modulo DEPTH, occupancy counter AW+1 bits.
- pop = out_valid & out_ready. push = in_valid & (level != DEPTH | pop); a full FIFO accepts a push in the same cycle as a pop.
- in_valid & ~push (full, no pop): byte dropped, overflow ← 1 and held until reset; level, pointers unchanged.
- level next = level + push − pop; push & pop together leave level unchanged.
- byte_count increments by 1 on every push; drops do not count.
- out_valid = (level != 0); out_data = mem[rd_ptr] when out_valid, else 8'h00 (combinational from registered state).
- Done tracking, states IDLE → PENDING → IDLE:
  - in_done_d registers in_done; rise = in_done & ~in_done_d.
  - IDLE: rise → PENDING.
  - PENDING: when level == 0 and push == 0 in the same cycle → done_out = 1 for that cycle and the state returns to IDLE; otherwise stay in PENDING.
  - A rise while already in PENDING is absorbed: one pulse only.
- done_out is registered: it asserts the cycle after the drain condition is met and lasts exactly one cycle.
- in_data is ignored when in_valid = 0.

## Timing
- Reset values: out_valid 0, out_data 8'h00, level 0, overflow 0, byte_count 0, done_out 0; pointers 0, state IDLE, in_done_d 0. Array contents are not reset.
- Reset mid-stream discards all buffered bytes and any pending done immediately (asynchronous).
- Push latency: a byte pushed at edge N is visible on out_data/out_valid after edge N (cycle N+1) when the FIFO was empty.
- Pop: out_data advances to the next entry after the edge where pop = 1.
- Throughput: 1 byte/cycle in and out simultaneously, sustained indefinitely with out_ready held at 1.
- Pointer wrap: after DEPTH pushes, wr_ptr returns to 0 with no bubble.
- in_done rising edge with FIFO already empty and no push: done_out is high in cycle N+2 relative to the rise sampled at edge N.

## Test plan
- Reset/idle: assert reset mid-cycle with 5 bytes buffered → level = 0, out_valid = 0, out_data = 8'h00, no done_out after release.
- Stream: push 0x01..0x20 (32 bytes) with out_ready = 1 → sink receives 0x01..0x20 in order, 1 per cycle, byte_count = 32, overflow = 0.
- Full/back-pressure: out_ready = 0, push 17 bytes 0xA0..0xB0 → level = 16, overflow = 1, 0xB0 dropped, byte_count = 16. Then out_ready = 1 → 0xA0..0xAF drain in order.
- Full with simultaneous push/pop: fill to 16, then in_valid = 1 and out_ready = 1 for 4 cycles → level stays 16, no overflow, order preserved.
- Done ordering: push 16 bytes with out_ready = 0, raise in_done and hold high for 40 cycles, release out_ready after 10 → exactly one done_out pulse, in the cycle after the 16th pop.
- Repeated done: two separate in_done rising edges on an empty FIFO → two single-cycle pulses. in_done held high → one pulse only.
